// File: rtl/binary_median3x3.sv
// 3x3 rank filter on a 1-bit pixel mask. Two line buffers feed a sliding 3x3 window.
// out_mask is set when the window popcount reaches THRESH. Syncs are delayed to match.
module binary_median3x3 #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int THRESH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic in_mask,
    input  logic in_de,
    input  logic in_hsync,
    input  logic in_vsync,
    output logic out_mask,
    output logic out_de,
    output logic out_hsync,
    output logic out_vsync
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [XW-1:0] X_END = XW'(IMG_W);
    localparam logic [YW-1:0] Y_END = YW'(IMG_H);
    localparam logic [XW-1:0] X_TWO = XW'(2);
    localparam logic [YW-1:0] Y_TWO = YW'(2);
    localparam logic [3:0]    S_MIN = 4'(THRESH);

    logic [XW-1:0] x_cnt, x1;
    logic [YW-1:0] y_cnt, y1;
    logic          de1, hs1, vs1;
    logic [8:0]    win;
    logic          lb0 [IMG_W];
    logic          lb1 [IMG_W];
    logic          x_ok;
    logic [AW-1:0] addr;
    logic [2:0]    col;
    logic [3:0]    s;

    assign x_ok = x_cnt < X_END;
    assign addr = x_ok ? x_cnt[AW-1:0] : '0;
    // Old RAM contents are read in the same cycle they are overwritten.
    assign col  = {lb1[addr], lb0[addr], in_mask};
    assign s    = 4'($countones(win));

    // Line buffer RAM is deliberately not reset; rows 0 and 1 are masked instead.
    always_ff @(posedge clk) begin
        if (ce && in_de && x_ok) begin
            lb0[addr] <= in_mask;
            lb1[addr] <= lb0[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            x1    <= '0;
            y1    <= '0;
            de1   <= 1'b0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            win   <= '0;
        end else if (ce) begin
            win <= {win[5:0], col};
            x1  <= x_cnt;
            y1  <= y_cnt;
            de1 <= in_de;
            hs1 <= in_hsync;
            vs1 <= in_vsync;

            if (in_de && x_ok)
                x_cnt <= x_cnt + 1'b1;
            else if (de1 && !in_de)
                x_cnt <= '0;

            // A vsync rise on the same cycle as a DE fall takes priority.
            if (in_vsync && !vs1)
                y_cnt <= '0;
            else if (de1 && !in_de && y_cnt != Y_END)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_mask  <= 1'b0;
            out_de    <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else if (ce) begin
            out_mask  <= de1 && (x1 >= X_TWO) && (y1 >= Y_TWO) &&
                         (x1 < X_END) && (y1 < Y_END) && (s >= S_MIN);
            out_de    <= de1;
            out_hsync <= hs1;
            out_vsync <= vs1;
        end
    end

endmodule

// File: tb/tb_binary_median3x3.sv
// Bench for binary_median3x3: three instances (THRESH 5, 9, 1) share one stream and are
// compared every cycle against a frame-array neighbourhood-count model.
`timescale 1ns/1ps
module tb_binary_median3x3;
    localparam int W  = 64;
    localparam int H  = 64;
    localparam int HB = 4;
    localparam int VB = 2;

    logic clk = 1'b0;
    logic rst_n, ce, in_mask, in_de, in_hsync, in_vsync;
    logic m5, de5, hs5, vs5;
    logic m9, de9, hs9, vs9;
    logic m1, de1o, hs1o, vs1o;

    binary_median3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_mask(in_mask), .in_de(in_de),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_mask(m5), .out_de(de5), .out_hsync(hs5), .out_vsync(vs5));
    binary_median3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_mask(in_mask), .in_de(in_de),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_mask(m9), .out_de(de9), .out_hsync(hs9), .out_vsync(vs9));
    binary_median3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_mask(in_mask), .in_de(in_de),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_mask(m1), .out_de(de1o), .out_hsync(hs1o), .out_vsync(vs1o));

    always #5 clk = ~clk;

    int total, bad;
    int n5, n9, n1;
    bit ce_tgl;
    bit src [H][W+2];
    bit img [H][W];
    int mx, my;
    bit m_de, m_vs;
    logic [7:0] e1, e2;   // {in-range, popcount[3:0], de, hs, vs}

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; m_de = 1'b0; m_vs = 1'b0; e1 = '0; e2 = '0;
    endtask

    task automatic model(input logic m, input logic de, input logic hs, input logic vs);
        bit cond;
        int cnt;
        cond = 1'b0;
        cnt  = 0;
        if (de && mx < W && my < H) img[my][mx] = m;
        if (de && mx >= 2 && my >= 2 && mx < W && my < H) begin
            cond = 1'b1;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++)
                    cnt += int'(img[my-dy][mx-dx]);
        end
        e2 = e1;
        e1 = {cond, 4'(cnt), de, hs, vs};
        if (de && mx < W) mx++;
        if (m_de && !de) begin
            mx = 0;
            if (my < H) my++;
        end
        if (vs && !m_vs) my = 0;
        m_de = de;
        m_vs = vs;
    endtask

    task automatic check_outputs();
        bit c;
        int s;
        c = e2[7];
        s = int'(e2[6:3]);
        chk("mask5", int'(m5), int'(c && s >= 5));
        chk("mask9", int'(m9), int'(c && s >= 9));
        chk("mask1", int'(m1), int'(c && s >= 1));
        chk("de",  int'(de5), int'(e2[2]));
        chk("hs",  int'(hs5), int'(e2[1]));
        chk("vs",  int'(vs5), int'(e2[0]));
        chk("sync9", int'({de9, hs9, vs9}),   int'(e2[2:0]));
        chk("sync1", int'({de1o, hs1o, vs1o}), int'(e2[2:0]));
        if (ce) begin
            n5 += int'(m5); n9 += int'(m9); n1 += int'(m1);
        end
    endtask

    task automatic step(input logic m, input logic de, input logic hs, input logic vs,
                        input logic c);
        @(negedge clk);
        check_outputs();
        in_mask = m; in_de = de; in_hsync = hs; in_vsync = vs; ce = c;
        if (c) model(m, de, hs, vs);
    endtask

    task automatic px(input logic m, input logic de, input logic hs, input logic vs);
        step(m, de, hs, vs, 1'b1);
        if (ce_tgl) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mask"}, int'({m5, m9, m1}), 0);
        chk({tag, "_sync"}, int'({de5, hs5, vs5, de9, hs9, vs9, de1o, hs1o, vs1o}), 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        check_outputs();
        ce = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic drive_frame(input int len, input bit tail, input int rst_line);
        for (int l = 0; l < VB; l++)
            for (int p = 0; p < W + HB; p++) px(1'b0, 1'b0, 1'b0, l == 0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < len; x++) begin
                px(src[y][x], 1'b1, 1'b0, 1'b0);
                if (y == rst_line && x == 32) async_reset();
            end
            if (tail || y != H - 1)
                for (int p = 0; p < HB; p++) px(1'b0, 1'b0, p < 2, 1'b0);
        end
    endtask

    task automatic fill_const(input bit v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W + 2; x++) src[y][x] = v;
    endtask

    task automatic fill_rand();
        int d;
        d = $urandom_range(30, 70);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W + 2; x++) src[y][x] = ($urandom_range(0, 99) < d);
    endtask

    task automatic run_counted(input string tag, input int x5, input int x9, input int x1);
        n5 = 0; n9 = 0; n1 = 0;
        drive_frame(W, 1'b1, -1);
        idle(8);
        chk({tag, "_ones5"}, n5, x5);
        chk({tag, "_ones9"}, n9, x9);
        chk({tag, "_ones1"}, n1, x1);
    endtask

    initial begin
        total = 0; bad = 0; n5 = 0; n9 = 0; n1 = 0; ce_tgl = 1'b0;
        rst_n = 1'b0; ce = 1'b0;
        in_mask = 1'b0; in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        model_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = 1'b0;
        #3 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fill_const(1'b1);
        run_counted("all_ones", 62 * 62, 62 * 62, 62 * 62);

        fill_const(1'b0);
        src[20][20] = 1'b1;
        run_counted("single", 0, 0, 9);

        for (int y = 10; y <= 12; y++)
            for (int x = 10; x <= 12; x++) src[y][x] = 1'b1;
        src[20][20] = 1'b0;
        run_counted("block", 5, 1, 25);

        fill_const(1'b1);
        ce_tgl = 1'b1;
        run_counted("ce_toggle", 62 * 62, 62 * 62, 62 * 62);
        ce_tgl = 1'b0;

        drive_frame(W, 1'b1, 30);
        run_counted("after_rst", 62 * 62, 62 * 62, 62 * 62);

        fill_rand();
        drive_frame(W + 2, 1'b1, -1);
        idle(8);

        fill_rand();
        drive_frame(W, 1'b0, -1);
        fill_rand();
        drive_frame(W, 1'b1, -1);
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
